// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the add/subtract datapath, reused by the ALU,
// the branch comparator and the pipelined adder.
package pipelined_addsub_pkg;

    typedef enum logic {
        ADDSUB_ADD = 1'b0,
        ADDSUB_SUB = 1'b1
    } addsub_op_e;

    // Bits handled by one pipeline slice; callers guarantee width % stages == 0.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder slice: reports its carry-out and the carry
// into its top bit so the caller can derive signed overflow.
module addsub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [SLICE:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    assign sum     = total[SLICE-1:0];
    assign cout    = total[SLICE];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out by XOR.
    assign msb_cin = a[SLICE-1] ^ b[SLICE-1] ^ total[SLICE-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one carry-propagating slice per register
// stage, valid/ready on both sides, carry/overflow/zero flags at the output.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    addsub_op_e       op;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Operands travel shifted right so the slice about to be consumed sits in
    // the low bits; results enter at the top and settle into place at the end.
    logic [STAGES-1:0] valid_q, valid_d, valid_in, ready;
    logic [STAGES-1:0] carry_q, carry_d, carry_in, slice_cout;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  res_q   [STAGES];
    logic [WIDTH-1:0]  res_d   [STAGES];
    logic [WIDTH-1:0]  a_in    [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic [WIDTH-1:0]  res_in  [STAGES];
    logic [WIDTH-1:0]  res_next[STAGES];
    logic [SLICE-1:0]  slice_sum    [STAGES];
    logic              slice_msb_cin[STAGES];
    logic              msb_cin_q, msb_cin_d;

    assign op    = addsub_op_e'(sub);
    assign b_eff = (op == ADDSUB_SUB) ? ~b : b;
    assign c0    = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign valid_in[k] = in_valid;
            assign a_in[k]     = a;
            assign b_in[k]     = b_eff;
            assign res_in[k]   = '0;
            assign carry_in[k] = c0;
        end else begin : g_next
            assign valid_in[k] = valid_q[k-1];
            assign a_in[k]     = a_q[k-1];
            assign b_in[k]     = b_q[k-1];
            assign res_in[k]   = res_q[k-1];
            assign carry_in[k] = carry_q[k-1];
        end

        addsub_slice #(.SLICE(SLICE)) u_slice (
            .a       (a_in[k][SLICE-1:0]),
            .b       (b_in[k][SLICE-1:0]),
            .cin     (carry_in[k]),
            .sum     (slice_sum[k]),
            .cout    (slice_cout[k]),
            .msb_cin (slice_msb_cin[k])
        );

        if (STAGES == 1) begin : g_single
            assign res_next[k] = slice_sum[k];
        end else begin : g_multi
            assign res_next[k] = {slice_sum[k], res_in[k][WIDTH-1:SLICE]};
        end
    end

    // Combinational ready chain lets a full pipe advance in lock-step with the consumer.
    always_comb begin
        logic chain;
        chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain    = chain || !valid_q[k];
            ready[k] = chain;
        end
    end

    always_comb begin
        // NOTE: every target gets its hold value first so no path leaves it unassigned (no latch).
        msb_cin_d = msb_cin_q;
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            res_d[k]   = res_q[k];
            carry_d[k] = carry_q[k];
            if (ready[k]) begin
                valid_d[k] = valid_in[k];
                if (valid_in[k]) begin
                    a_d[k]     = a_in[k] >> SLICE;
                    b_d[k]     = b_in[k] >> SLICE;
                    res_d[k]   = res_next[k];
                    carry_d[k] = slice_cout[k];
                end
            end
        end
        if (ready[STAGES-1] && valid_in[STAGES-1]) begin
            msb_cin_d = slice_msb_cin[STAGES-1];
        end
    end

    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            carry_q   <= '0;
            msb_cin_q <= 1'b0;
            // NOTE: data arrays are cleared too so all outputs read zero out of reset.
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign overflow  = msb_cin_q ^ carry_q[STAGES-1];
    // Qualified by out_valid so the flag reads 0 from an empty pipe.
    assign zero      = out_valid && (res_q[STAGES-1] == '0);

endmodule
